// File: rtl/full_subtr_pkg.sv
// Shared definitions for the ripple-borrow subtractor: default width, legal
// width range, result/borrow-chain types and the per-bit subtract equations.
// Optional feature macro used by the top level: FULL_SUBTR_OVF_EN.
package full_subtr_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32'd8;
  localparam int unsigned MIN_WIDTH     = 32'd2;
  localparam int unsigned MAX_WIDTH     = 32'd32;

  // Result is one bit wider than the operands: the top bit is the final borrow.
  typedef logic [DEFAULT_WIDTH:0]   diff_t;
  typedef logic [DEFAULT_WIDTH-1:0] borrow_vec_t;

  // Difference bit of a 1-bit full subtractor.
  function automatic logic fs_diff(
    input logic a_i,
    input logic b_i,
    input logic bin
  );
    return a_i ^ b_i ^ bin;
  endfunction

  // Borrow out of a 1-bit full subtractor: borrow when a < b, or when the
  // bits are equal and a borrow is already coming in.
  function automatic logic fs_borrow(
    input logic a_i,
    input logic b_i,
    input logic bin
  );
    return (~a_i & b_i) | (~(a_i ^ b_i) & bin);
  endfunction

  // Two's-complement overflow of a - b: operand signs differ and the result
  // sign differs from the minuend sign.
  function automatic logic fs_signed_ovf(
    input logic a_msb,
    input logic b_msb,
    input logic d_msb
  );
    return (a_msb ^ b_msb) & (a_msb ^ d_msb);
  endfunction

endpackage

// File: rtl/fs_bit_cell.sv
// One-bit full subtractor cell: d = a - b - bin, bout = borrow out.
// Purely combinational; chained bout -> bin by the top level.
module fs_bit_cell
  import full_subtr_pkg::*;
(
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);

  logic w_d;
  logic w_bout;

  // Difference and borrow for this bit position.
  always_comb begin
    w_d    = fs_diff(i_a, i_b, i_bin);
    w_bout = fs_borrow(i_a, i_b, i_bin);
  end

  assign o_d    = w_d;
  assign o_bout = w_bout;

endmodule

// File: rtl/ripple_full_subtractor.sv
// Registered WIDTH-bit ripple-borrow subtractor: s = a - b - cin as a
// (WIDTH+1)-bit two's-complement value, plus the per-bit borrow chain.
// One output register stage; in_valid is the capture enable and out_valid
// is its one-cycle-delayed copy.
// Optional macro FULL_SUBTR_OVF_EN adds a registered signed-overflow flag ovf.
module ripple_full_subtractor
  import full_subtr_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH:0]   s,
  output logic [WIDTH-1:0] cout
`ifdef FULL_SUBTR_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Reject widths the borrow chain is not meant to support.
  generate
    if ((WIDTH < MIN_WIDTH) || (WIDTH > MAX_WIDTH)) begin : g_bad_width
      $error("ripple_full_subtractor: WIDTH out of range 2..32");
    end
  endgenerate

  // w_borrow[0] is the external borrow-in; w_borrow[i+1] is the borrow out
  // of bit i, so w_borrow[WIDTH] is the final borrow.
  logic [WIDTH:0]   w_borrow;
  logic [WIDTH-1:0] w_d;
  logic [WIDTH:0]   w_s;
  logic [WIDTH-1:0] w_cout;

  logic             r_out_valid;
  logic [WIDTH:0]   r_s;
  logic [WIDTH-1:0] r_cout;

  assign w_borrow[0] = cin;

  // Ripple chain: one cell per bit, borrow out feeds the next bit's borrow in.
  generate
    for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_cell
      fs_bit_cell u_cell (
        .i_a    (a[gi]),
        .i_b    (b[gi]),
        .i_bin  (w_borrow[gi]),
        .o_d    (w_d[gi]),
        .o_bout (w_borrow[gi+1])
      );
    end
  endgenerate

  // Assemble the combinational result and the exported borrow chain.
  always_comb begin
    w_s    = {w_borrow[WIDTH], w_d};
    w_cout = w_borrow[WIDTH:1];
  end

  // Valid pipeline: out_valid follows in_valid by exactly one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
    end
  end

  // Result register: capture on in_valid, otherwise hold the last result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s    <= '0;
      r_cout <= '0;
    end else if (in_valid) begin
      r_s    <= w_s;
      r_cout <= w_cout;
    end else begin
      r_s    <= r_s;
      r_cout <= r_cout;
    end
  end

`ifdef FULL_SUBTR_OVF_EN
  logic w_ovf;
  logic r_ovf;

  // Signed overflow of a - b - cin, taken from operand and difference MSBs.
  always_comb begin
    w_ovf = fs_signed_ovf(a[WIDTH-1], b[WIDTH-1], w_d[WIDTH-1]);
  end

  // Overflow flag shares the capture enable and latency of the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (in_valid) begin
      r_ovf <= w_ovf;
    end else begin
      r_ovf <= r_ovf;
    end
  end

  assign ovf = r_ovf;
`endif

  assign out_valid = r_out_valid;
  assign s         = r_s;
  assign cout      = r_cout;

endmodule

// File: tb/tb_ripple_full_subtractor.sv
// Scoreboard bench for ripple_full_subtractor (WIDTH = 8). The driver pushes
// the expected result when it presents a valid input; the monitor pops and
// compares whenever out_valid is high and checks the hold value otherwise.
module tb_ripple_full_subtractor;
  import full_subtr_pkg::*;

  localparam int W = DEFAULT_WIDTH;

  typedef struct packed {
    diff_t       s;
    borrow_vec_t cout;
    logic        ovf;
  } exp_t;

  typedef struct packed {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vc;
    diff_t        vs;
    borrow_vec_t  vcout;
    logic         vovf;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  diff_t        s;
  borrow_vec_t  cout;
`ifdef FULL_SUBTR_OVF_EN
  logic         ovf;
`endif

  exp_t        q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  diff_t       hold_s = '0;
  borrow_vec_t hold_cout = '0;
  logic        hold_ovf = 1'b0;

  // Hand-computed directed vectors: a, b, cin, s, cout, ovf.
  vec_t dir [0:10] = '{
    '{8'd5,   8'd3,   1'b0, 9'd2,   8'h02, 1'b0},
    '{8'd3,   8'd5,   1'b0, 9'd510, 8'hFC, 1'b0},
    '{8'd0,   8'd0,   1'b1, 9'd511, 8'hFF, 1'b0},
    '{8'd10,  8'd4,   1'b1, 9'd5,   8'h05, 1'b0},
    '{8'd255, 8'd255, 1'b1, 9'd511, 8'hFF, 1'b0},
    '{8'd128, 8'd1,   1'b0, 9'd127, 8'h7F, 1'b1},
    '{8'd1,   8'd2,   1'b0, 9'd511, 8'hFE, 1'b0},
    '{8'h5A,  8'h5A,  1'b0, 9'd0,   8'h00, 1'b0},
    '{8'd255, 8'd0,   1'b1, 9'd254, 8'h00, 1'b0},
    '{8'd0,   8'd255, 1'b1, 9'd256, 8'hFF, 1'b0},
    '{8'd9,   8'd2,   1'b0, 9'd7,   8'h06, 1'b0}
  };

  ripple_full_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .s         (s),
    .cout      (cout)
`ifdef FULL_SUBTR_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: arithmetic difference, prefix comparison for each
  // borrow, signed range test for overflow.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc);
    exp_t e;
    int   sa;
    int   sb;
    int   sd;
    e.s = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mc};
    for (int i = 0; i < W; i++) begin
      logic [W:0] pa;
      logic [W:0] pb;
      pa = '0;
      pb = '0;
      for (int j = 0; j <= i; j++) begin
        pa[j] = ma[j];
        pb[j] = mb[j];
      end
      e.cout[i] = (pa < (pb + {{W{1'b0}}, mc}));
    end
    sa = $signed(ma);
    sb = $signed(mb);
    sd = sa - sb - int'(mc);
    e.ovf = (sd > ((2 ** (W - 1)) - 1)) || (sd < -(2 ** (W - 1)));
    return e;
  endfunction

  task automatic drive(input logic v, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                       input logic tc, input exp_t e);
    @(posedge clk);
    #1;
    in_valid = v;
    a        = ta;
    b        = tb_;
    cin      = tc;
    if (v) q.push_back(e);
  endtask

  task automatic summary();
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
  endtask

  // Monitor: compare fresh results against the scoreboard, hold values otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold_s    = '0;
      hold_cout = '0;
      hold_ovf  = 1'b0;
    end else if (out_valid) begin
      if (q.size() == 0) begin
        check("spurious_out_valid", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("s", s, e.s);
        check("cout", cout, e.cout);
        check("cout_msb_vs_s_msb", cout[W-1], s[W]);
`ifdef FULL_SUBTR_OVF_EN
        check("ovf", ovf, e.ovf);
`endif
        hold_s    = e.s;
        hold_cout = e.cout;
        hold_ovf  = e.ovf;
      end
    end else begin
      check("hold_s", s, hold_s);
      check("hold_cout", cout, hold_cout);
`ifdef FULL_SUBTR_OVF_EN
      check("hold_ovf", ovf, hold_ovf);
`endif
    end
  end

  // Watchdog: the run must always reach its summary line.
  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    summary();
    $finish;
  end

  // Stimulus sequence.
  initial begin
    exp_t e;
    #1;
    check("reset_out_valid", out_valid, 32'd0);
    check("reset_s", s, 32'd0);
    check("reset_cout", cout, 32'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;

    // Directed boundary and example vectors with hand-computed results.
    foreach (dir[k]) begin
      e.s    = dir[k].vs;
      e.cout = dir[k].vcout;
      e.ovf  = dir[k].vovf;
      drive(1'b1, dir[k].va, dir[k].vb, dir[k].vc, e);
    end

    // Hold: last valid was 9-2; operands wander while in_valid is low.
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, W'($urandom), W'($urandom), 1'($urandom), e);
    end

    // Sweep a, b over 0..7 with cin=0, back to back.
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        drive(1'b1, W'(i), W'(j), 1'b0, model(W'(i), W'(j), 1'b0));
      end
    end

    // Random back-to-back operands.
    for (int k = 0; k < 10000; k++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      drive(1'b1, ra, rb, rc, model(ra, rb, rc));
    end

    // Mid-stream reset with in_valid high: the pending input is discarded.
    drive(1'b1, 8'd200, 8'd17, 1'b0, model(8'd200, 8'd17, 1'b0));
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("async_reset_out_valid", out_valid, 32'd0);
    check("async_reset_s", s, 32'd0);
    check("async_reset_cout", cout, 32'd0);
    q.delete();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    check("reset_held_out_valid", out_valid, 32'd0);
    check("reset_held_s", s, 32'd0);
    rst = 1'b0;

    // Capture resumes on the first valid edge after reset release.
    drive(1'b1, 8'd5, 8'd3, 1'b0, model(8'd5, 8'd3, 1'b0));
    drive(1'b1, 8'd128, 8'd1, 1'b0, model(8'd128, 8'd1, 1'b0));
    drive(1'b0, 8'd0, 8'd0, 1'b0, e);

    // Drain and make sure every expected result was produced.
    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_empty", q.size(), 32'd0);
    summary();
    $finish;
  end

endmodule
